// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_slice.sv
// Combinational 1-bit full adder built from two half-adder stages.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1;
    logic hc1;
    logic hc2;

    // The first half adder combines the operand bits; the second folds in carry-in.
    assign hs1 = a ^ b;
    assign hc1 = a & b;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: loads an operand pair, adds it LSB-first through a
// single full-adder slice, and returns sum/cout over a valid/ready handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               slice_s;
    logic               slice_co;
    logic               last_bit;

    serial_fa_slice u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The result registers update only on the final bit, so sum/cout hold their
    // last value outside DONE instead of showing partial sums during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= {slice_s, sum_sh[WIDTH-1:1]};
                    carry_q <= slice_co;
                    if (last_bit) begin
                        sum_q  <= {slice_s, sum_sh[WIDTH-1:1]};
                        cout_q <= slice_co;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven and random checks for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then performs one input handshake.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Counts edges after the handshake edge until out_valid rises.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result(input int bp);
        out_ready = 1'b0;
        repeat (bp) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           input int bp, output logic [W-1:0] s, output logic c,
                           output int lat);
        issue(xa, xb, xc);
        wait_done(lat);
        s = sum;
        c = cout;
        release_result(bp);
    endtask

    initial begin
        logic [W-1:0] s;
        logic         c;
        int           lat;
        logic [W:0]   ref_full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, s, c, lat);
            check($sformatf("vec%0d_sum", i), s, vecs[i].s);
            check($sformatf("vec%0d_cout", i), c, vecs[i].co);
            check($sformatf("vec%0d_latency", i), lat, 8);
        end

        // Backpressure: 0xC3+0x3D+1 = 0x101, result must hold for 5 stalled cycles.
        issue(8'hC3, 8'h3D, 1'b1);
        wait_done(lat);
        check("bp_latency", lat, 8);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", sum, 8'h01);
            check("bp_cout", cout, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);

        // Operands and in_valid churn during RUN must not disturb the sampled pair.
        issue(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            in_valid = ~in_valid;
            step();
        end
        in_valid = 1'b0;
        wait_done(lat);
        check("run_in_ready_done", in_ready, 0);
        check("churn_sum", sum, 8'h46);
        check("churn_cout", cout, 0);
        release_result(0);

        // Reset on the third RUN cycle abandons the operation.
        issue(8'hAA, 8'h55, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sum", sum, 0);
        run_txn(8'h01, 8'h01, 1'b0, 1, s, c, lat);
        check("postrst_sum", s, 8'h02);
        check("postrst_cout", c, 0);
        check("postrst_latency", lat, 8);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_txn(ra, rb, rc, $urandom_range(0, 3), s, c, lat);
            check("rand_sum", s, ref_full[W-1:0]);
            check("rand_cout", c, ref_full[W]);
            check("rand_latency", lat, 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
